// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared encodings for the LED pattern scheduler.
//   MODE_*   : pattern select values carried on cmd_mode
//   state_t  : scheduler FSM state encoding
//   PWM_W    : width of the dimming PWM counter and duty field
//              (used only when LED_PATTERN_DIM_EN is defined)
// ---------------------------------------------------------------------------
package led_pattern_pkg;

   localparam logic [1:0] MODE_FILL   = 2'd0;
   localparam logic [1:0] MODE_CHASE  = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   localparam int PWM_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/led_pattern_prescaler.sv
// ---------------------------------------------------------------------------
// led_pattern_prescaler
// Step-rate divider. Counts 0..div-1 while enabled and pulses tick on the
// cycle where the count equals div-1, then wraps to 0.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : hold the count at 0 and suppress tick (scheduler idle)
//   div    : clocks per step, must be nonzero (caller maps 0 to 1)
//   tick   : one-cycle step strobe
// ---------------------------------------------------------------------------
module led_pattern_prescaler #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = !clear && (cnt == (div - DIV_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
// Command-driven LED bar scheduler. A command (mode, div, reps) is accepted
// over a valid/ready handshake in IDLE; the selected pattern then advances
// once every div clocks for reps full periods (reps=0: until stop), after
// which the bar is cleared and done pulses for one cycle.
//
// Optional build macro: LED_PATTERN_DIM_EN
//   Adds cmd_duty (latched on accept) and a free-running PWM counter;
//   led_out is the pattern gated by (pwm_cnt <= duty).
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (IDLE only)
//   cmd_mode   : 0 FILL, 1 CHASE, 2 BOUNCE, 3 BLINK
//   cmd_div    : clocks per step, 0 treated as 1
//   cmd_reps   : full periods to run, 0 = until stop
//   cmd_duty   : dimming duty (LED_PATTERN_DIM_EN only)
//   stop       : abort the running pattern, no done
//   led_out    : LED drive
//   busy       : pattern running
//   done       : one-cycle pulse on normal completion
//
// State table
//   state   | meaning
//   ST_IDLE | waiting for a command, cmd_ready high, bar holds last value
//   ST_RUN  | pattern stepping on prescaler ticks, busy high
// ---------------------------------------------------------------------------
module led_pattern_ctrl
   import led_pattern_pkg::*;
#(
   parameter int LED_W = 8,
   parameter int DIV_W = 16,
   parameter int REP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [DIV_W-1:0] cmd_div,
   input  logic [REP_W-1:0] cmd_reps,
`ifdef LED_PATTERN_DIM_EN
   input  logic [PWM_W-1:0] cmd_duty,
`endif
   input  logic             stop,
   output logic [LED_W-1:0] led_out,
   output logic             busy,
   output logic             done
);

   localparam logic [LED_W-1:0] MSB_ONE = {1'b1, {(LED_W-1){1'b0}}};

   state_t           state_q, state_d;
   logic [LED_W-1:0] pat_q, pat_d;
   logic             dir_q, dir_d;      // bounce direction: 0 = toward LSB
   logic [1:0]       mode_q, mode_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [REP_W-1:0] reps_q, reps_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             done_q, done_d;

   logic             tick;
   logic [LED_W-1:0] pat_step;
   logic             dir_step;
   logic             period_end;
   logic [LED_W-1:0] pat_start;
   logic             last_rep;

`ifdef LED_PATTERN_DIM_EN
   logic [PWM_W-1:0] duty_q, duty_d;
   logic [PWM_W-1:0] pwm_cnt;
`endif

   led_pattern_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state_q != ST_RUN),
      .div   (div_q),
      .tick  (tick)
   );

   // Pattern successor for the latched mode, plus a flag marking the step
   // that completes one full period of that pattern.
   always_comb begin
      pat_step   = pat_q;
      dir_step   = dir_q;
      period_end = 1'b0;
      case (mode_q)
         MODE_FILL: begin
            if (&pat_q) begin
               pat_step   = '0;
               period_end = 1'b1;
            end else begin
               pat_step = {1'b1, pat_q[LED_W-1:1]};
            end
         end
         MODE_CHASE: begin
            pat_step   = {pat_q[0], pat_q[LED_W-1:1]};
            period_end = pat_q[0];
         end
         MODE_BOUNCE: begin
            pat_step = dir_q ? (pat_q << 1) : (pat_q >> 1);
            // Direction follows where the lit lamp lands, so a 2-wide bar
            // turns around correctly at both ends.
            if (pat_step[LED_W-1]) begin
               dir_step   = 1'b0;
               period_end = 1'b1;
            end else if (pat_step[0]) begin
               dir_step = 1'b1;
            end
         end
         MODE_BLINK: begin
            pat_step   = (pat_q == '0) ? '1 : '0;
            period_end = (pat_q != '0);
         end
         default: begin
            pat_step = pat_q;
         end
      endcase
   end

   always_comb begin
      pat_start = '0;
      if ((cmd_mode == MODE_CHASE) || (cmd_mode == MODE_BOUNCE)) begin
         pat_start = MSB_ONE;
      end
   end

   assign last_rep = period_end && (reps_q != '0) &&
                     (rep_cnt_q == (reps_q - REP_W'(1)));

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      dir_d     = dir_q;
      mode_d    = mode_q;
      div_d     = div_q;
      reps_d    = reps_q;
      rep_cnt_d = rep_cnt_q;
      done_d    = 1'b0;
`ifdef LED_PATTERN_DIM_EN
      duty_d    = duty_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // stop has no meaning here; a command is taken regardless
            if (cmd_valid) begin
               state_d   = ST_RUN;
               mode_d    = cmd_mode;
               div_d     = (cmd_div == '0) ? DIV_W'(1) : cmd_div;
               reps_d    = cmd_reps;
               rep_cnt_d = '0;
               dir_d     = 1'b0;
               pat_d     = pat_start;
`ifdef LED_PATTERN_DIM_EN
               duty_d    = cmd_duty;
`endif
            end
         end
         ST_RUN: begin
            if (stop) begin
               pat_d   = '0;
               state_d = ST_IDLE;
            end else if (tick) begin
               if (last_rep) begin
                  pat_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pat_d = pat_step;
                  dir_d = dir_step;
                  if (period_end && (rep_cnt_q != '1)) begin
                     rep_cnt_d = rep_cnt_q + REP_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pat_q     <= '0;
         dir_q     <= 1'b0;
         mode_q    <= MODE_FILL;
         div_q     <= DIV_W'(1);
         reps_q    <= '0;
         rep_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         dir_q     <= dir_d;
         mode_q    <= mode_d;
         div_q     <= div_d;
         reps_q    <= reps_d;
         rep_cnt_q <= rep_cnt_d;
         done_q    <= done_d;
      end
   end

`ifdef LED_PATTERN_DIM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q  <= '1;
         pwm_cnt <= '0;
      end else begin
         duty_q  <= duty_d;
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   assign led_out = pat_q & {LED_W{pwm_cnt <= duty_q}};
`else
   assign led_out = pat_q;
`endif

   assign busy      = (state_q == ST_RUN);
   assign cmd_ready = (state_q == ST_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [15:0] cmd_div;
   logic [7:0]  cmd_reps;
   logic        stop;
   logic [7:0]  led_out;
   logic        busy;
   logic        done;
`ifdef LED_PATTERN_DIM_EN
   logic [3:0]  cmd_duty;
`endif

   int checks = 0;
   int errors = 0;

   led_pattern_ctrl #(
      .LED_W (8),
      .DIV_W (16),
      .REP_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_div   (cmd_div),
      .cmd_reps  (cmd_reps),
`ifdef LED_PATTERN_DIM_EN
      .cmd_duty  (cmd_duty),
`endif
      .stop      (stop),
      .led_out   (led_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] prev;
      int pos;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_mode  = 2'd0;
      cmd_div   = 16'd0;
      cmd_reps  = 8'd0;
      stop      = 1'b0;
`ifdef LED_PATTERN_DIM_EN
      cmd_duty  = 4'd15;
`endif
      nclk(2);
      check("reset_led", led_out, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ready", cmd_ready, 1'b1);
      rst_n = 1'b1;
      nclk(1);

      // FILL, div=2, reps=1
      cmd_mode = 2'd0; cmd_div = 16'd2; cmd_reps = 8'd1; cmd_valid = 1'b1;
      nclk(1);
      cmd_valid = 1'b0; cmd_div = 16'd7; cmd_reps = 8'd9;
      check("fill_start_led", led_out, 8'h00);
      check("fill_start_busy", busy, 1'b1);
      check("fill_start_ready", cmd_ready, 1'b0);
      prev = 8'h00;
      for (int k = 0; k < 8; k++) begin
         nclk(1);
         check("fill_hold", led_out, prev);
         nclk(1);
         v = 8'hFF;
         v = v << (7 - k);
         check("fill_step", led_out, v);
         check("fill_no_done", done, 1'b0);
         prev = v;
      end
      nclk(1);
      check("fill_hold_full", led_out, 8'hFF);
      nclk(1);
      check("fill_end_led", led_out, 8'h00);
      check("fill_end_done", done, 1'b1);
      check("fill_end_busy", busy, 1'b0);
      check("fill_end_ready", cmd_ready, 1'b1);
      nclk(1);
      check("fill_done_pulse", done, 1'b0);

      // CHASE, div=0 -> 1, reps=2, cmd_valid held with a different command
      cmd_mode = 2'd1; cmd_div = 16'd0; cmd_reps = 8'd2; cmd_valid = 1'b1;
      nclk(1);
      cmd_mode = 2'd3; cmd_div = 16'd5; cmd_reps = 8'd0;
      check("chase_start_led", led_out, 8'h80);
      check("chase_ready_low", cmd_ready, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         nclk(1);
         v = 8'h80;
         v = v >> (k % 8);
         check("chase_step", led_out, v);
         check("chase_busy", busy, 1'b1);
         check("chase_no_done", done, 1'b0);
         if (k == 15) cmd_valid = 1'b0;
      end
      nclk(1);
      check("chase_end_led", led_out, 8'h00);
      check("chase_end_done", done, 1'b1);
      check("chase_end_ready", cmd_ready, 1'b1);
      nclk(1);
      check("chase_idle_busy", busy, 1'b0);
      check("chase_done_pulse", done, 1'b0);

      // BOUNCE, div=1, reps=1
      cmd_mode = 2'd2; cmd_div = 16'd1; cmd_reps = 8'd1; cmd_valid = 1'b1;
      nclk(1);
      cmd_valid = 1'b0;
      check("bounce_start", led_out, 8'h80);
      for (int k = 1; k <= 13; k++) begin
         nclk(1);
         pos = (k <= 7) ? (7 - k) : (k - 7);
         v = 8'h01;
         v = v << pos;
         check("bounce_step", led_out, v);
         check("bounce_no_done", done, 1'b0);
      end
      nclk(1);
      check("bounce_end_led", led_out, 8'h00);
      check("bounce_end_done", done, 1'b1);
      check("bounce_end_busy", busy, 1'b0);

      // BLINK, div=3, reps=0, stop coincident with a tick
      nclk(1);
      cmd_mode = 2'd3; cmd_div = 16'd3; cmd_reps = 8'd0; cmd_valid = 1'b1;
      nclk(1);
      cmd_valid = 1'b0;
      check("blink_start", led_out, 8'h00);
      nclk(3);
      check("blink_on", led_out, 8'hFF);
      nclk(3);
      check("blink_off", led_out, 8'h00);
      nclk(2);
      check("blink_pre_stop", led_out, 8'h00);
      check("blink_pre_stop_busy", busy, 1'b1);
      stop = 1'b1;
      nclk(1);
      check("stop_led", led_out, 8'h00);
      check("stop_no_done", done, 1'b0);
      check("stop_busy", busy, 1'b0);
      check("stop_ready", cmd_ready, 1'b1);

      // stop still high in IDLE must not block a new command
      cmd_mode = 2'd0; cmd_div = 16'd1; cmd_reps = 8'd1; cmd_valid = 1'b1;
      nclk(1);
      stop = 1'b0; cmd_valid = 1'b0;
      check("reaccept_busy", busy, 1'b1);
      check("reaccept_led", led_out, 8'h00);
      nclk(1);
      check("reaccept_step1", led_out, 8'h80);
      nclk(1);
      check("reaccept_step2", led_out, 8'hC0);

      // asynchronous reset mid-run
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_led", led_out, 8'h00);
      check("midreset_busy", busy, 1'b0);
      check("midreset_ready", cmd_ready, 1'b1);
      check("midreset_done", done, 1'b0);
      nclk(1);
      rst_n = 1'b1;
      nclk(2);
      check("post_reset_idle", busy, 1'b0);
      check("post_reset_led", led_out, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
